instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries and maximum credits (legal values 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken; load a new fetch PC.
REQ-006 SHALL have port redirect_pc  input  64  target PC for redirect.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  output  64  fetch address, bits [1:0] always 0.
REQ-010 SHALL have port imem_resp_valid  input  1  in-order response valid, one per accepted request, latency >= 1 cycle.
REQ-011 SHALL have port imem_resp_data  input  32  instruction word.
REQ-012 SHALL have port inst_valid  output  1  buffered instruction available to decode.
REQ-013 SHALL have port inst_ready  input  1  decode consumes instruction.
REQ-014 SHALL have port inst_pc  output  64  PC of presented instruction.
REQ-015 SHALL have port inst_data  output  32  presented instruction word.

Function
REQ-016 SHALL keep a registered fetch_pc; imem_req_addr SHALL equal fetch_pc.
REQ-017 SHALL treat a request as accepted when imem_req_valid and imem_req_ready are both 1; fetch_pc then advances by 4, wrapping modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-018 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
REQ-019 SHALL assert imem_req_valid only in RUN and only when outstanding + buffer occupancy < BUF_DEPTH (credit rule; no response is ever dropped for lack of space).
REQ-020 SHALL push the PC of each accepted request into a tag queue and pop it on each imem_resp_valid, writing {pc, data} into the instruction buffer.
REQ-021 SHALL present the buffer head on inst_valid/inst_pc/inst_data; it SHALL pop when inst_valid and inst_ready are both 1.
REQ-022 SHALL give a minimum response-to-inst_valid latency of 1 cycle (registered buffer, no combinational bypass).
REQ-023 SHALL sustain one instruction per cycle when imem_req_ready=1, response latency=1, inst_ready=1.
REQ-024 SHALL implement states RUN and FLUSH; RUN -> FLUSH on redirect with stale responses pending; FLUSH -> RUN when drop count reaches 0; redirect with nothing pending stays in RUN.
REQ-025 On redirect_valid SHALL, in that cycle's edge: load fetch_pc <= {redirect_pc[63:2], 2'b00}, empty the instruction buffer and tag queue, and set drop count = outstanding after this cycle's accept/response.
REQ-026 A request accepted in the redirect cycle SHALL count as stale; a response arriving in the redirect cycle SHALL be discarded and not counted.
REQ-027 An inst handshake in the redirect cycle SHALL complete (the consumer owns that instruction); the remaining entries are flushed.
REQ-028 In FLUSH SHALL discard responses, decrement drop count per response, keep imem_req_valid=0 and inst_valid=0.
REQ-029 Redirect during FLUSH SHALL reload fetch_pc and keep the drop count per REQ-025.

Reset
REQ-030 While reset=1 SHALL hold imem_req_valid=0 and inst_valid=0; at the edge it SHALL set fetch_pc=RESET_PC, buffer/tag queue empty, outstanding=0, drop count=0, state=RUN.
REQ-031 Reset SHALL override redirect and any in-flight responses; responses to requests issued before reset are the environment's responsibility to suppress.
REQ-032 In the first cycle after reset falls SHALL drive imem_req_valid=1, imem_req_addr=RESET_PC.

Structure
REQ-033 Shared package fetch_pkg SHALL hold XLEN=64, INST_W=32, PC_STEP=4 and the state enum {RUN, FLUSH}.
REQ-034 SHALL instantiate sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) twice: instruction buffer (96 bits) and PC tag queue (64 bits).

Verification
REQ-035 Reset, RESET_PC=64'h1000, memory ready, latency 1, inst_ready=1 -> inst_pc 1000,1004,1008 on consecutive cycles.
REQ-036 inst_ready=0 for 10 cycles -> at most BUF_DEPTH (2) requests accepted, imem_req_valid=0 afterward, no data lost when ready returns.
REQ-037 Latency 3, redirect to 64'h2002 with 2 outstanding -> 2 responses discarded, next inst_pc=2000, no stale PC reaches decode.
REQ-038 redirect_pc=64'h4000 in same cycle as request accept and inst handshake -> handshake instruction taken once, accepted request dropped, next inst_pc=4000.
REQ-039 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> addresses ...FFF8, ...FFFC, 0, 4.
REQ-040 Assert reset mid-stream with full buffer -> next cycle inst_valid=0, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and fetch FSM states
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush and occupancy count
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(D+1)-1:0]   count
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(D - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(D);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= push_data;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-based instruction fetch with redirect flush
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 64'd0,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, tag_pc;
  logic [XLEN+INST_W-1:0] head;
  logic [CW-1:0] drop, drop_n, outs, tag_cnt, buf_cnt;
  logic tag_full, tag_empty, buf_full, buf_empty;
  logic run, credit, req_fire, inst_fire, resp_take;
  assign run = state == RUN && !reset;
  assign inst_valid = run && !buf_empty;
  assign inst_fire = inst_valid && inst_ready;
  // a same-cycle decode pop frees a slot, which keeps a depth-2 buffer streaming
  assign credit = int'(tag_cnt) + int'(buf_cnt) - int'(inst_fire) < BUF_DEPTH;
  assign imem_req_valid = run && credit;
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_take = imem_resp_valid && run && !redirect_valid && !tag_empty;
  assign outs = state == RUN ? tag_cnt : drop;
  assign {inst_pc, inst_data} = head;
  always_comb begin
    fetch_pc_n = req_fire ? fetch_pc + PC_STEP : fetch_pc;
    drop_n = state == FLUSH && imem_resp_valid ? drop - 1'b1 : drop;
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc & ~64'd3;
      drop_n = outs + CW'(req_fire) - CW'(imem_resp_valid);
    end
    state_n = drop_n != '0 ? FLUSH : RUN;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      drop <= '0;
      fetch_pc <= RESET_PC & ~64'd3;
    end else begin
      state <= state_n;
      drop <= drop_n;
      fetch_pc <= fetch_pc_n;
    end
  // requests accepted in a redirect cycle are stale and never get a tag
  sync_fifo #(.W(XLEN), .D(BUF_DEPTH)) u_tag (
    .clk(clk),
    .rst(reset),
    .flush(redirect_valid),
    .push(req_fire && !redirect_valid && !tag_full),
    .push_data(fetch_pc),
    .pop(resp_take),
    .pop_data(tag_pc),
    .full(tag_full),
    .empty(tag_empty),
    .count(tag_cnt)
  );
  sync_fifo #(.W(XLEN + INST_W), .D(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(reset),
    .flush(redirect_valid),
    .push(resp_take && !buf_full),
    .push_data({tag_pc, imem_resp_data}),
    .pop(inst_fire),
    .pop_data(head),
    .full(buf_full),
    .empty(buf_empty),
    .count(buf_cnt)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with variable-latency memory model
module tb_instr_fetch_unit;
  localparam logic [63:0] RPC = 64'h1000;
  typedef struct {logic [63:0] pc; logic [31:0] d;} ent_t;
  logic clk = 0, reset = 1, redirect_valid = 0, imem_req_ready = 1, inst_ready = 1;
  logic [63:0] redirect_pc = '0;
  logic imem_req_valid, imem_resp_valid, inst_valid;
  logic [63:0] imem_req_addr, inst_pc;
  logic [31:0] imem_resp_data, inst_data;
  int checks = 0, errors = 0, lat = 1, acc_cnt = 0, s;
  logic [3:0] pv;
  logic [63:0] pa [4];
  ent_t sb [$];
  ent_t e;
  logic [63:0] next_addr, redir_tgt;
  bit first_after = 0, expect_both = 0;
  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  // in-order memory: an accept enters stage lat-1 and is answered when it reaches stage 0
  always @(posedge clk)
    if (reset) pv <= '0;
    else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[3] <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_req_addr;
      end
    end
  assign imem_resp_valid = pv[0];
  assign imem_resp_data = mdata(pa[0]);

  always @(negedge clk)
    if (reset) begin
      sb.delete();
      next_addr = RPC;
      first_after = 0;
    end else begin
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_data", 64'(inst_data), 64'(e.d));
        end
        if (first_after) begin
          chk("redir_first_pc", inst_pc, redir_tgt);
          first_after = 0;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        acc_cnt++;
        chk("req_addr", imem_req_addr, next_addr);
        if (!redirect_valid) sb.push_back('{next_addr, mdata(next_addr)});
        next_addr += 64'd4;
      end
      if (redirect_valid) begin
        if (expect_both) begin
          chk("redir_accept", 64'(imem_req_valid && imem_req_ready), 64'd1);
          chk("redir_handshake", 64'(inst_valid && inst_ready), 64'd1);
        end
        sb.delete();
        redir_tgt = redirect_pc & ~64'd3;
        next_addr = redir_tgt;
        first_after = 1;
      end
    end

  // second instance starting near the top of the address space
  logic w_req_valid, w_resp_valid, w_inst_valid;
  logic [63:0] w_addr, w_raddr, w_inst_pc;
  logic [31:0] w_inst_data;
  logic [63:0] w_exp [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
  int w_idx, w_pidx;
  instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(64'd0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_raddr[31:0]),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_pc(w_inst_pc), .inst_data(w_inst_data)
  );
  always @(posedge clk)
    if (reset) w_resp_valid <= 1'b0;
    else begin
      w_resp_valid <= w_req_valid;
      w_raddr <= w_addr;
    end
  always @(negedge clk)
    if (reset) begin
      w_idx = 0;
      w_pidx = 0;
    end else begin
      if (w_req_valid && w_idx < 4) begin
        chk("wrap_addr", w_addr, w_exp[w_idx]);
        w_idx++;
      end
      if (w_inst_valid && w_pidx < 4) begin
        chk("wrap_inst_pc", w_inst_pc, w_exp[w_pidx]);
        chk("wrap_inst_data", 64'(w_inst_data), 64'(w_exp[w_pidx][31:0]));
        w_pidx++;
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 reset = 1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_rst_addr", imem_req_addr, RPC);
    chk("post_rst_inst_valid", 64'(inst_valid), 64'd0);
  endtask

  initial begin
    do_reset(2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("stream_valid", 64'(inst_valid), 64'd1);
      chk("stream_pc", inst_pc, RPC + 64'(4 * i));
      @(negedge clk);
    end
    @(posedge clk);
    #1 inst_ready = 0;
    s = acc_cnt;
    repeat (10) @(negedge clk);
    chk("stall_accepts_le_depth", 64'(acc_cnt - s <= 2), 64'd1);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_inst_valid", 64'(inst_valid), 64'd1);
    @(posedge clk);
    #1 inst_ready = 1;
    cyc(8);
    imem_req_ready = 0;
    cyc(6);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_inst_valid", 64'(inst_valid), 64'd0);
    @(posedge clk);
    #1 imem_req_ready = 1;
    cyc(5);
    expect_both = 1;
    redirect_valid = 1;
    redirect_pc = 64'h4000;
    cyc(1);
    redirect_valid = 0;
    expect_both = 0;
    cyc(8);
    @(negedge clk);
    chk("redir_4000_resumed", 64'(first_after), 64'd0);
    lat = 3;
    do_reset(1);
    cyc(1);
    cyc(1);
    redirect_valid = 1;
    redirect_pc = 64'h2002;
    @(negedge clk);
    chk("credit_exhausted", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("flush_req_valid", 64'(imem_req_valid), 64'd0);
    chk("flush_inst_valid", 64'(inst_valid), 64'd0);
    cyc(15);
    @(negedge clk);
    chk("redir_2000_resumed", 64'(first_after), 64'd0);
    @(posedge clk);
    #1 inst_ready = 0;
    cyc(10);
    @(negedge clk);
    chk("full_before_reset", 64'(inst_valid), 64'd1);
    do_reset(1);
    @(posedge clk);
    #1 inst_ready = 1;
    cyc(12);
    imem_req_ready = 0;
    cyc(10);
    @(negedge clk);
    chk("final_drain_empty", 64'(sb.size()), 64'd0);
    chk("wrap_seen", 64'(w_pidx), 64'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
